tdm_frame_scheduler: RTL and testbench
======================================

Name: tdm_frame_scheduler

Overview:
- Sequences the serial TDM data-stream multiplexer.
- Owns the bit-rate tick and the slot schedule, and pulls bytes from up to three 8-bit source channels through valid/ready handshakes.
- Serializes those bytes MSB-first onto one line in fixed slot order 0,1,2, and flags frame boundaries and per-slot underruns for the downstream framer/monitor.

Parameters:
CLK_DIV, 100, clk cycles per serial bit (>=2)
IDLE_BYTE, 8'h00, byte sent when an active slot's channel has no valid data
FRAME_CNT_W, 16, width of frame counter

Ports:
clk  in  1  system clock
rst  in  1  reset
mode  in  2  active slots: 0=off, 1=slot0, 2=slots0-1, 3=slots0-2
ch_data  in  24  channel bytes; [7:0]=ch0, [15:8]=ch1, [23:16]=ch2
ch_valid  in  3  per-channel byte valid
ch_ready  out  3  per-channel accept strobe
ser_data  out  1  serial output
ser_sync  out  1  high during first bit period of each frame
slot_id  out  2  slot owning the current bit on ser_data
frame_done  out  1  one-clk pulse at end of each frame
underrun  out  1  one-clk pulse when IDLE_BYTE substituted
frame_cnt  out  FRAME_CNT_W  completed frames, wraps

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk, all logic on its rising edge.
  - rst forces: ser_data=0, ser_sync=0, slot_id=0, ch_ready=0, frame_done=0, underrun=0, frame_cnt=0, divider=0, state=IDLE.
  - rst mid-frame aborts the frame; there is no resumption and no frame_done.
- Tick generation:
  - Divider counts 0..CLK_DIV-1, free-running out of reset.
  - tick is an internal one-clk pulse when divider==CLK_DIV-1.
  - ser_data changes only on tick clocks.
- States: IDLE, LOAD, SHIFT, FRAME_END.
- IDLE:
  - On tick, ser_data<=0 and ser_sync<=0.
  - On tick with mode!=0: latch mode into act_mode, slot<=0, go LOAD.
  - mode==0 stays IDLE.
- LOAD (exactly one clk):
  - ch_ready[slot]=ch_valid[slot], combinational from state/slot; all other ch_ready bits are 0.
  - If valid, shreg<=ch_data byte for slot.
  - Else shreg<=IDLE_BYTE and underrun pulses this clk.
  - A byte counts as transferred only on a clk with ch_valid & ch_ready both high.
  - Then go SHIFT.
- SHIFT:
  - On each tick: ser_data<=shreg[7], shreg<<=1, slot_id<=slot, bitcnt++.
  - ser_sync<=1 on the tick emitting bit 7 of slot 0, and 0 on every other tick.
  - After the tick emitting bit 0 (bitcnt==7): bitcnt<=0.
    - If slot < act_mode-1: slot++, go LOAD.
    - Else go FRAME_END.
- FRAME_END (one clk):
  - frame_done pulses; frame_cnt++ (wraps from all-ones to 0).
  - If mode!=0: re-latch act_mode, slot<=0, go LOAD. Frames are back-to-back with no gap bit.
  - Else go IDLE.
  - The last bit remains on ser_data until the next tick.
- Mode changes:
  - mode is sampled only in IDLE and FRAME_END.
  - A change mid-frame takes effect at the next frame.
- Bit period and frame length:
  - Every bit period is exactly CLK_DIV clk. LOAD/FRAME_END never fall on a tick boundary conflict, because they occupy the clk after a tick and CLK_DIV>=2.
  - Frame length = 8*act_mode bit periods.
- Simultaneous events: ch_valid deasserted in the same clk as LOAD counts as underrun. ch_valid of non-owning channels is ignored.
- Handshake rules:
  - A source must hold ch_data stable while ch_valid is high.
  - ch_ready never asserts more than once per slot.

Test Plan:
- CLK_DIV=4, mode=1, ch0 valid 8'hA5 continuously:
  - ser_data per tick is 1,0,1,0,0,1,0,1, repeating every 32 clk.
  - ser_sync high on the first bit of each group of 8.
  - frame_done every 32 clk; ch_ready[0] one pulse per frame.
- mode=3, ch0=8'h81, ch1=8'h3C, ch2=8'hFF all valid:
  - 24-bit stream 10000001_00111100_11111111.
  - slot_id 0/1/2 per byte; ch_ready pulses in order 0,1,2.
  - frame_cnt increments by 1 per 24 ticks.
- mode=2, ch1_valid=0:
  - Slot 1 emits IDLE_BYTE 8'h00.
  - underrun pulses once per frame in slot-1 LOAD; ch_ready[1] stays 0.
- Mode changes:
  - mode 3->1 during slot 1: current frame completes all 24 bits, next frame is 8 bits.
  - mode->0 mid-frame: frame completes, frame_done pulses, then IDLE with ser_data=0.
- Reset and wrap:
  - rst asserted mid-SHIFT of slot 2: next clk all outputs at reset values, frame_cnt=0, no frame_done.
  - After release with mode=1, the first ser_sync occurs on the first tick after LOAD.
  - With FRAME_CNT_W=2, frame_cnt sequence 1,2,3,0.

Source files
------------

// File: rtl/tdm_frame_scheduler.sv
// TDM frame scheduler: generates the serial bit tick, walks slots 0..act_mode-1,
// pulls one byte per slot over valid/ready and shifts it out MSB-first.
module tdm_frame_scheduler #(
    parameter int          CLK_DIV     = 100,
    parameter logic [7:0]  IDLE_BYTE   = 8'h00,
    parameter int          FRAME_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             mode,
    input  logic [23:0]            ch_data,
    input  logic [2:0]             ch_valid,
    output logic [2:0]             ch_ready,
    output logic                   ser_data,
    output logic                   ser_sync,
    output logic [1:0]             slot_id,
    output logic                   frame_done,
    output logic                   underrun,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    localparam int DIV_W = $clog2(CLK_DIV);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, FRAME_END} state_t;

    state_t           state;
    state_t           next_state;
    logic [DIV_W-1:0] divider;
    logic             tick;
    logic [1:0]       act_mode;
    logic [1:0]       slot;
    logic [1:0]       last_slot;
    logic [7:0]       shreg;
    logic [2:0]       bitcnt;
    logic             sel_valid;
    logic [7:0]       sel_byte;
    logic [2:0]       sel_onehot;

    assign tick      = (divider == DIV_W'(CLK_DIV - 1));
    assign last_slot = act_mode - 2'd1;

    // Free-running bit-period divider; tick marks the last clk of each period.
    always_ff @(posedge clk) begin
        if (rst) begin
            divider <= '0;
        end else if (tick) begin
            divider <= '0;
        end else begin
            divider <= divider + DIV_W'(1);
        end
    end

    // Route the channel owning the current slot onto a common select path.
    always_comb begin
        sel_valid  = 1'b0;
        sel_byte   = IDLE_BYTE;
        sel_onehot = 3'b000;
        case (slot)
            2'd0: begin
                sel_valid  = ch_valid[0];
                sel_byte   = ch_data[7:0];
                sel_onehot = 3'b001;
            end
            2'd1: begin
                sel_valid  = ch_valid[1];
                sel_byte   = ch_data[15:8];
                sel_onehot = 3'b010;
            end
            2'd2: begin
                sel_valid  = ch_valid[2];
                sel_byte   = ch_data[23:16];
                sel_onehot = 3'b100;
            end
            default: ;
        endcase
    end

    // Scheduler state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic plus the single-clk handshake and status strobes.
    always_comb begin
        next_state = state;
        ch_ready   = 3'b000;
        underrun   = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (tick && mode != 2'd0) begin
                    next_state = LOAD;
                end
            end
            LOAD: begin
                ch_ready   = sel_valid ? sel_onehot : 3'b000;
                underrun   = !sel_valid;
                next_state = SHIFT;
            end
            SHIFT: begin
                if (tick && bitcnt == 3'd7) begin
                    next_state = (slot < last_slot) ? LOAD : FRAME_END;
                end
            end
            FRAME_END: begin
                frame_done = 1'b1;
                next_state = (mode != 2'd0) ? LOAD : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Datapath: byte capture, serial shifting, slot walk and frame counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            ser_data  <= 1'b0;
            ser_sync  <= 1'b0;
            slot_id   <= 2'd0;
            frame_cnt <= '0;
            act_mode  <= 2'd0;
            slot      <= 2'd0;
            shreg     <= 8'h00;
            bitcnt    <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (tick) begin
                        ser_data <= 1'b0;
                        ser_sync <= 1'b0;
                        if (mode != 2'd0) begin
                            act_mode <= mode;
                            slot     <= 2'd0;
                        end
                    end
                end
                LOAD: begin
                    shreg <= sel_valid ? sel_byte : IDLE_BYTE;
                end
                SHIFT: begin
                    if (tick) begin
                        ser_data <= shreg[7];
                        shreg    <= {shreg[6:0], 1'b0};
                        slot_id  <= slot;
                        ser_sync <= (slot == 2'd0) && (bitcnt == 3'd0);
                        bitcnt   <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7 && slot < last_slot) begin
                            slot <= slot + 2'd1;
                        end
                    end
                end
                FRAME_END: begin
                    frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
                    slot      <= 2'd0;
                    if (mode != 2'd0) begin
                        act_mode <= mode;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tdm_frame_scheduler.sv
// Scoreboard bench for tdm_frame_scheduler: expected per-tick bits and per-frame
// summaries are queued when each phase is set up and checked as the DUT emits them.
module tb_tdm_frame_scheduler;

    localparam int         CLK_DIV   = 4;
    localparam int         FCW       = 2;
    localparam logic [7:0] IDLE_BYTE = 8'h00;

    logic           clk      = 1'b0;
    logic           rst      = 1'b1;
    logic [1:0]     mode     = 2'd0;
    logic [23:0]    ch_data  = 24'h0;
    logic [2:0]     ch_valid = 3'b000;
    logic [2:0]     ch_ready;
    logic           ser_data;
    logic           ser_sync;
    logic [1:0]     slot_id;
    logic           frame_done;
    logic           underrun;
    logic [FCW-1:0] frame_cnt;

    tdm_frame_scheduler #(
        .CLK_DIV    (CLK_DIV),
        .IDLE_BYTE  (IDLE_BYTE),
        .FRAME_CNT_W(FCW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .ch_data   (ch_data),
        .ch_valid  (ch_valid),
        .ch_ready  (ch_ready),
        .ser_data  (ser_data),
        .ser_sync  (ser_sync),
        .slot_id   (slot_id),
        .frame_done(frame_done),
        .underrun  (underrun),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       d;
        logic       s;
        logic [1:0] id;
    } bit_exp_t;

    typedef struct packed {
        logic [FCW-1:0] cnt;
        logic [5:0]     seq;
        logic [1:0]     unr;
    } frame_exp_t;

    bit_exp_t   bit_q[$];
    frame_exp_t frame_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [1:0] plan[8];
    int         plan_len;

    int         div_m     = 0;
    logic       tick_seen = 1'b0;
    logic       rst_seen  = 1'b1;
    logic       last_ser  = 1'b0;
    logic [5:0] ready_seq = 6'd0;
    logic [1:0] unr_cnt   = 2'd0;
    bit_exp_t   be;
    frame_exp_t fe;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference bit clock: knows which posedges are bit ticks.
    always @(posedge clk) begin
        tick_seen <= !rst && (div_m == CLK_DIV - 1);
        rst_seen  <= rst;
        if (rst || div_m == CLK_DIV - 1) div_m <= 0;
        else                             div_m <= div_m + 1;
    end

    // Monitor: compare emitted bits per tick and frame summaries per frame_done.
    always @(negedge clk) begin
        if (rst_seen) begin
            last_ser  = 1'b0;
            ready_seq = 6'd0;
            unr_cnt   = 2'd0;
        end else begin
            if (tick_seen) begin
                if (bit_q.size() != 0) begin
                    be = bit_q.pop_front();
                    checkOutput("ser_data", 32'(ser_data), 32'(be.d));
                    checkOutput("ser_sync", 32'(ser_sync), 32'(be.s));
                    checkOutput("slot_id", 32'(slot_id), 32'(be.id));
                end
                last_ser = ser_data;
            end else begin
                checkOutput("ser_hold", 32'(ser_data), 32'(last_ser));
            end
            for (int i = 0; i < 3; i++) begin
                if (ch_ready[i]) begin
                    ready_seq = {ready_seq[3:0], 2'(i + 1)};
                    checkOutput("ready_needs_valid", 32'(ch_valid[i]), 32'(1));
                end
            end
            if (underrun) unr_cnt = unr_cnt + 2'd1;
            if (frame_done) begin
                checkOutput("fd_expected", 32'(frame_q.size() != 0), 32'(1));
                if (frame_q.size() != 0) begin
                    fe = frame_q.pop_front();
                    checkOutput("frame_cnt", 32'(frame_cnt), 32'(fe.cnt));
                    checkOutput("ready_order", 32'(ready_seq), 32'(fe.seq));
                    checkOutput("underrun_cnt", 32'(unr_cnt), 32'(fe.unr));
                end
                ready_seq = 6'd0;
                unr_cnt   = 2'd0;
            end
        end
    end

    // Queue the expected bits of one slot.
    task automatic pushSlot(input logic [23:0] data, input logic [2:0] valid, input int s, input int nbits);
        logic [7:0] byte_v;
        byte_v = valid[s] ? data[8*s +: 8] : IDLE_BYTE;
        for (int b = 7; b > 7 - nbits; b--) begin
            bit_q.push_back('{d: byte_v[b], s: (s == 0 && b == 7), id: 2'(s)});
        end
    endtask

    // Reset, queue expectations for the frames in plan[], then drive mode per frame.
    task automatic applyStimulus(input logic [23:0] data, input logic [2:0] valid);
        logic [5:0] seq;
        logic [1:0] unr;
        logic [1:0] last_id;
        int         budget;
        rst  = 1'b1;
        mode = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        bit_q.delete();
        frame_q.delete();
        last_id = 2'd0;
        bit_q.push_back('{d: 1'b0, s: 1'b0, id: 2'd0});
        for (int f = 0; f < plan_len; f++) begin
            seq = 6'd0;
            unr = 2'd0;
            for (int s = 0; s < int'(plan[f]); s++) begin
                pushSlot(data, valid, s, 8);
                if (valid[s]) seq = {seq[3:0], 2'(s + 1)};
                else          unr = unr + 2'd1;
            end
            last_id = plan[f] - 2'd1;
            frame_q.push_back('{cnt: FCW'(f), seq: seq, unr: unr});
        end
        repeat (2) bit_q.push_back('{d: 1'b0, s: 1'b0, id: last_id});
        ch_data  = data;
        ch_valid = valid;
        mode     = plan[0];
        rst      = 1'b0;
        repeat (5) @(posedge clk);
        for (int i = 0; i < plan_len; i++) begin
            repeat ((plan[i] >= 2'd2) ? 40 : 10) @(posedge clk);
            #1;
            mode = (i + 1 < plan_len) ? plan[i + 1] : 2'd0;
            budget = 0;
            do begin
                @(negedge clk);
                budget++;
            end while (!frame_done && budget < 400);
            checkOutput("frame_done_seen", 32'(frame_done), 32'(1));
            @(posedge clk);
            #1;
        end
        budget = 0;
        while (bit_q.size() != 0 && budget < 200) begin
            @(posedge clk);
            budget++;
        end
        checkOutput("bits_left", 32'(bit_q.size()), 32'(0));
        checkOutput("frames_left", 32'(frame_q.size()), 32'(0));
        checkOutput("frame_cnt_end", 32'(frame_cnt), 32'(plan_len % 4));
    endtask

    initial begin
        int budget;
        $display("[TB] start");

        plan = '{2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
        plan_len = 3;
        applyStimulus(24'h0000A5, 3'b111);

        plan = '{2'd3, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
        plan_len = 2;
        applyStimulus(24'hFF3C81, 3'b111);

        plan = '{2'd2, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
        plan_len = 2;
        applyStimulus(24'h005AC3, 3'b101);

        plan = '{2'd3, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0};
        plan_len = 5;
        applyStimulus(24'hFF3C81, 3'b111);

        // Reset in the middle of slot 2 of the second frame.
        rst  = 1'b1;
        mode = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        bit_q.delete();
        frame_q.delete();
        bit_q.push_back('{d: 1'b0, s: 1'b0, id: 2'd0});
        for (int s = 0; s < 3; s++) pushSlot(24'hFF3C81, 3'b111, s, 8);
        pushSlot(24'hFF3C81, 3'b111, 0, 8);
        pushSlot(24'hFF3C81, 3'b111, 1, 8);
        pushSlot(24'hFF3C81, 3'b111, 2, 4);
        frame_q.push_back('{cnt: FCW'(0), seq: 6'h1B, unr: 2'd0});
        ch_data  = 24'hFF3C81;
        ch_valid = 3'b111;
        mode     = 2'd3;
        rst      = 1'b0;
        budget   = 0;
        while (bit_q.size() != 0 && budget < 400) begin
            @(posedge clk);
            budget++;
        end
        checkOutput("pre_reset_bits_left", 32'(bit_q.size()), 32'(0));
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_ser_data", 32'(ser_data), 32'(0));
        checkOutput("rst_ser_sync", 32'(ser_sync), 32'(0));
        checkOutput("rst_slot_id", 32'(slot_id), 32'(0));
        checkOutput("rst_ch_ready", 32'(ch_ready), 32'(0));
        checkOutput("rst_frame_done", 32'(frame_done), 32'(0));
        checkOutput("rst_underrun", 32'(underrun), 32'(0));
        checkOutput("rst_frame_cnt", 32'(frame_cnt), 32'(0));
        checkOutput("rst_frames_left", 32'(frame_q.size()), 32'(0));

        plan = '{2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
        plan_len = 1;
        applyStimulus(24'h0000A5, 3'b001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
